// File: rtl/vector_alu_seq.sv
// Command sequencer for the 32-bit VectorALU: streams LEN element pairs from a
// dual-read scratchpad through the ALU and writes each result back.
module vector_alu_seq #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_opcode,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [31:0]       rd_data_a,
    input  logic [31:0]       rd_data_b,
    output logic [7:0]        alu_opcode,
    output logic [31:0]       alu_in1,
    output logic [31:0]       alu_in2,
    input  logic [31:0]       alu_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [7:0] OP_RELU    = 8'h05;
    localparam logic [7:0] OP_ADD     = 8'h06;
    localparam logic [7:0] OP_SOFTMAX = 8'h07;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] src_a_reg, src_b_reg, wr_addr_reg;
    logic [LEN_W-1:0]  len_reg, idx_reg;
    logic [7:0]        opcode_reg;
    logic              err_reg;
    logic              v1_reg, v2_reg;

    logic              accept;
    logic              legal_op;
    logic              start_ok;
    logic              last_issue;
    logic [ADDR_W-1:0] idx_addr;

    assign legal_op   = (cmd_opcode == OP_RELU) || (cmd_opcode == OP_ADD) ||
                        (cmd_opcode == OP_SOFTMAX);
    assign start_ok   = legal_op && (cmd_len != '0);
    assign accept     = cmd_valid && (state_reg == IDLE);
    assign last_issue = (idx_reg == len_reg - LEN_W'(1));
    assign idx_addr   = ADDR_W'(idx_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (accept) state_next = start_ok ? ISSUE : DONE;
            ISSUE: if (last_issue) state_next = DRAIN;
            // v1 low means the final read has already moved into the ALU, so
            // both valids are clear by the time DONE is reached.
            DRAIN: if (!v1_reg) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            src_a_reg   <= '0;
            src_b_reg   <= '0;
            wr_addr_reg <= '0;
            len_reg     <= '0;
            idx_reg     <= '0;
            opcode_reg  <= 8'h00;
            err_reg     <= 1'b0;
            v1_reg      <= 1'b0;
            v2_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            v1_reg    <= rd_en;
            v2_reg    <= v1_reg;

            if (state_reg == ISSUE) idx_reg <= idx_reg + LEN_W'(1);
            if (wr_en) wr_addr_reg <= wr_addr_reg + ADDR_W'(1);
            if (state_reg == DONE) opcode_reg <= 8'h00;

            if (accept) begin
                src_a_reg   <= cmd_src_a;
                src_b_reg   <= cmd_src_b;
                wr_addr_reg <= cmd_dst;
                len_reg     <= cmd_len;
                idx_reg     <= '0;
                err_reg     <= !legal_op;
                opcode_reg  <= start_ok ? cmd_opcode : 8'h00;
            end
        end
    end

    assign cmd_ready  = (state_reg == IDLE);
    assign busy       = (state_reg != IDLE);
    assign rd_en      = (state_reg == ISSUE);
    assign done       = (state_reg == DONE);
    assign err        = (state_reg == DONE) && err_reg;
    assign rd_addr_a  = src_a_reg + idx_addr;
    assign rd_addr_b  = src_b_reg + idx_addr;
    assign alu_opcode = opcode_reg;
    assign alu_in1    = rd_data_a;
    assign alu_in2    = rd_data_b;
    assign wr_en      = v2_reg;
    assign wr_addr    = wr_addr_reg;
    assign wr_data    = alu_out;

endmodule

// File: tb/tb_vector_alu_seq.sv
// Directed bench for vector_alu_seq with a registered-read scratchpad and a
// 1-cycle-latency stand-in ALU around the DUT.
module tb_vector_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [9:0]  cmd_src_a, cmd_src_b, cmd_dst;
    logic [9:0]  cmd_len;
    logic        rd_en;
    logic [9:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic [7:0]  alu_opcode;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy, done, err;

    logic [31:0] mem [1024];
    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [31:0] pre_data;

    int tests = 0;
    int fails = 0;

    // results of the most recent run_cmd
    int          w_done, w_done_cnt, w_rd, w_wr, w_first_wr, w_last_wr, w_err, w_ready_after, w_busy1;
    logic [7:0]  w_op1;
    int          w_rd_addr_q[$];
    int          w_wr_addr_q[$];

    always #5 clk = ~clk;

    vector_alu_seq #(.ADDR_W(10), .LEN_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    function automatic logic [31:0] alu_model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            8'h05:   return a[31] ? 32'h0 : a;
            8'h06:   return a + b;
            default: return 32'h0;   // softmax stand-in yields zero
        endcase
    endfunction

    always @(posedge clk) begin
        alu_out <= alu_model(alu_opcode, alu_in1, alu_in2);
        if (rd_en) begin
            rd_data_a <= mem[rd_addr_a];
            rd_data_b <= mem[rd_addr_b];
        end
        if (wr_en) mem[wr_addr] <= wr_data;
        if (pre_we) mem[pre_addr] <= pre_data;
    end

    task automatic preload(input int addr, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = 10'(addr); pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issue one command and watch it cycle by cycle; cycle 1 is the one after the accept edge.
    task automatic run_cmd(input logic [7:0] op, input int sa, input int sb, input int dst, input int len);
        w_done = -1; w_done_cnt = 0; w_rd = 0; w_wr = 0; w_first_wr = -1; w_last_wr = -1;
        w_err = -1; w_ready_after = -1; w_busy1 = -1; w_op1 = 8'hxx;
        w_rd_addr_q.delete(); w_wr_addr_q.delete();
        @(negedge clk);
        cmd_opcode = op; cmd_src_a = 10'(sa); cmd_src_b = 10'(sb); cmd_dst = 10'(dst); cmd_len = 10'(len);
        cmd_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 1) begin
                cmd_valid = 1'b0;
                w_op1 = alu_opcode;
                w_busy1 = int'(busy);
            end
            if (rd_en) begin w_rd++; w_rd_addr_q.push_back(int'(rd_addr_a)); end
            if (wr_en) begin
                w_wr++; w_wr_addr_q.push_back(int'(wr_addr));
                if (w_first_wr < 0) w_first_wr = c;
                w_last_wr = c;
            end
            if (w_done >= 0 && c == w_done + 1) begin
                w_ready_after = int'(cmd_ready);
                break;
            end
            if (done) begin
                w_done_cnt++;
                if (w_done < 0) begin w_done = c; w_err = int'(err); end
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        tests++; if ({rd_en, wr_en, busy, done, err} !== 5'b0) begin fails++; $display("FAIL rst_strobes: got %b want 00000", {rd_en, wr_en, busy, done, err}); end
        tests++; if (alu_opcode !== 8'h00) begin fails++; $display("FAIL rst_alu_opcode: got %h want 00", alu_opcode); end
        tests++; if ({rd_addr_a, rd_addr_b, wr_addr} !== 30'h0) begin fails++; $display("FAIL rst_addrs: got %h want 0", {rd_addr_a, rd_addr_b, wr_addr}); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if ({cmd_ready, busy} !== 2'b10) begin fails++; $display("FAIL post_rst_idle: got %b want 10", {cmd_ready, busy}); end
    endtask

    task automatic test_add;
        preload(0, 32'd1); preload(1, 32'd2); preload(2, 32'd3); preload(3, 32'hFFFF_FFFF);
        preload(16, 32'd10); preload(17, 32'd20); preload(18, 32'd30); preload(19, 32'd1);
        run_cmd(8'h06, 0, 16, 32, 4);
        tests++; if (w_done !== 7) begin fails++; $display("FAIL add_done_cycle: got %0d want 7", w_done); end
        tests++; if (w_done_cnt !== 1) begin fails++; $display("FAIL add_done_width: got %0d want 1", w_done_cnt); end
        tests++; if (w_err !== 0) begin fails++; $display("FAIL add_err: got %0d want 0", w_err); end
        tests++; if (w_rd !== 4 || w_wr !== 4) begin fails++; $display("FAIL add_counts: got rd=%0d wr=%0d want 4/4", w_rd, w_wr); end
        tests++; if (w_first_wr !== 3 || w_last_wr !== 6) begin fails++; $display("FAIL add_wr_window: got %0d..%0d want 3..6", w_first_wr, w_last_wr); end
        tests++; if (w_op1 !== 8'h06 || w_busy1 !== 1) begin fails++; $display("FAIL add_op_busy: got op=%h busy=%0d want 06/1", w_op1, w_busy1); end
        tests++; if (w_ready_after !== 1) begin fails++; $display("FAIL add_ready_after: got %0d want 1", w_ready_after); end
        tests++; if (mem[32] !== 32'd11 || mem[33] !== 32'd22 || mem[34] !== 32'd33 || mem[35] !== 32'd0)
            begin fails++; $display("FAIL add_data: got %0d %0d %0d %0d want 11 22 33 0", mem[32], mem[33], mem[34], mem[35]); end
        tests++; if (alu_opcode !== 8'h00) begin fails++; $display("FAIL add_op_idle: got %h want 00", alu_opcode); end
    endtask

    task automatic test_relu;
        preload(100, 32'd5); preload(101, 32'h8000_0001); preload(102, 32'd0);
        preload(200, 32'd7); preload(201, 32'd7); preload(202, 32'd7);
        preload(300, 32'hAAAA); preload(301, 32'hAAAA); preload(302, 32'hAAAA);
        run_cmd(8'h05, 100, 200, 300, 3);
        tests++; if (w_rd !== 3 || w_wr !== 3) begin fails++; $display("FAIL relu_counts: got rd=%0d wr=%0d want 3/3", w_rd, w_wr); end
        tests++; if (w_done !== 6) begin fails++; $display("FAIL relu_done_cycle: got %0d want 6", w_done); end
        tests++; if (mem[300] !== 32'd5 || mem[301] !== 32'd0 || mem[302] !== 32'd0)
            begin fails++; $display("FAIL relu_data: got %h %h %h want 5 0 0", mem[300], mem[301], mem[302]); end
    endtask

    task automatic test_degenerate;
        run_cmd(8'h06, 0, 16, 400, 0);
        tests++; if (w_done !== 1 || w_err !== 0) begin fails++; $display("FAIL len0_done: got cyc=%0d err=%0d want 1/0", w_done, w_err); end
        tests++; if (w_rd !== 0 || w_wr !== 0) begin fails++; $display("FAIL len0_traffic: got rd=%0d wr=%0d want 0/0", w_rd, w_wr); end
        tests++; if (w_ready_after !== 1) begin fails++; $display("FAIL len0_ready: got %0d want 1", w_ready_after); end
        run_cmd(8'h09, 0, 16, 400, 5);
        tests++; if (w_done !== 1 || w_err !== 1) begin fails++; $display("FAIL illegal_done: got cyc=%0d err=%0d want 1/1", w_done, w_err); end
        tests++; if (w_rd !== 0 || w_wr !== 0) begin fails++; $display("FAIL illegal_traffic: got rd=%0d wr=%0d want 0/0", w_rd, w_wr); end
        tests++; if (w_op1 !== 8'h00) begin fails++; $display("FAIL illegal_opcode_out: got %h want 00", w_op1); end
    endtask

    task automatic test_wrap;
        int exp_addr[4] = '{1022, 1023, 0, 1};
        preload(1022, 32'd0); preload(1023, 32'd5); preload(0, 32'd0); preload(1, 32'd5);
        run_cmd(8'h07, 1022, 500, 1022, 4);
        tests++; if (w_rd_addr_q.size() !== 4 || w_wr_addr_q.size() !== 4)
            begin fails++; $display("FAIL wrap_counts: got rd=%0d wr=%0d want 4/4", w_rd_addr_q.size(), w_wr_addr_q.size()); end
        for (int k = 0; k < 4; k++) begin
            if (k < w_rd_addr_q.size() && k < w_wr_addr_q.size()) begin
                tests++; if (w_rd_addr_q[k] !== exp_addr[k] || w_wr_addr_q[k] !== exp_addr[k])
                    begin fails++; $display("FAIL wrap_addr[%0d]: got rd=%0d wr=%0d want %0d", k, w_rd_addr_q[k], w_wr_addr_q[k], exp_addr[k]); end
            end
        end
        tests++; if (mem[1022] !== 0 || mem[1023] !== 0 || mem[0] !== 0 || mem[1] !== 0)
            begin fails++; $display("FAIL wrap_data: got %0d %0d %0d %0d want 0 0 0 0", mem[1022], mem[1023], mem[0], mem[1]); end
    endtask

    task automatic test_back_to_back;
        int acc = -1, last_wr1 = -1, first_wr2 = -1, d2 = -1;
        preload(0, 32'd1); preload(1, 32'd2); preload(2, 32'd3); preload(3, 32'hFFFF_FFFF);
        @(negedge clk);
        cmd_opcode = 8'h06; cmd_src_a = 10'd0; cmd_src_b = 10'd16; cmd_dst = 10'd40; cmd_len = 10'd4;
        cmd_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) begin cmd_src_a = 10'd16; cmd_src_b = 10'd16; cmd_dst = 10'd50; cmd_len = 10'd2; end
            if (wr_en) last_wr1 = c;
            if (cmd_ready) begin acc = c; break; end
        end
        tests++; if (acc !== 8) begin fails++; $display("FAIL b2b_accept_cycle: got %0d want 8", acc); end
        tests++; if (last_wr1 !== 6) begin fails++; $display("FAIL b2b_first_last_wr: got %0d want 6", last_wr1); end
        @(posedge clk);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
            if (wr_en && first_wr2 < 0) first_wr2 = c;
            if (done) begin d2 = c; break; end
        end
        tests++; if (first_wr2 !== 3 || d2 !== 5) begin fails++; $display("FAIL b2b_second_timing: got wr=%0d done=%0d want 3/5", first_wr2, d2); end
        tests++; if (mem[40] !== 32'd11 || mem[43] !== 32'd0 || mem[50] !== 32'd20 || mem[51] !== 32'd40)
            begin fails++; $display("FAIL b2b_data: got %0d %0d %0d %0d want 11 0 20 40", mem[40], mem[43], mem[50], mem[51]); end
    endtask

    task automatic test_reset_mid;
        int wr_seen = 0, done_seen = 0;
        for (int k = 0; k < 8; k++) preload(600 + k, 32'hDEAD_0000 + 32'(k));
        @(negedge clk);
        cmd_opcode = 8'h06; cmd_src_a = 10'd0; cmd_src_b = 10'd16; cmd_dst = 10'd600; cmd_len = 10'd8;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if (wr_en !== 1'b0 || rd_en !== 1'b0) begin fails++; $display("FAIL rstmid_strobes: got rd=%b wr=%b want 0/0", rd_en, wr_en); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            if (wr_en) wr_seen++;
            if (done) done_seen++;
        end
        tests++; if (wr_seen !== 0 || done_seen !== 0) begin fails++; $display("FAIL rstmid_quiet: got wr=%0d done=%0d want 0/0", wr_seen, done_seen); end
        tests++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || alu_opcode !== 8'h00)
            begin fails++; $display("FAIL rstmid_idle: got ready=%b busy=%b op=%h want 1/0/00", cmd_ready, busy, alu_opcode); end
        tests++; if (mem[600] !== 32'hDEAD_0000) begin fails++; $display("FAIL rstmid_mem: got %h want dead0000", mem[600]); end
        run_cmd(8'h06, 0, 16, 610, 2);
        tests++; if (w_done !== 5 || mem[610] !== 32'd11 || mem[611] !== 32'd22)
            begin fails++; $display("FAIL rstmid_recover: got done=%0d data=%0d,%0d want 5 11,22", w_done, mem[610], mem[611]); end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = 8'h00;
        cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0; cmd_len = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (2) @(posedge clk);
        test_reset;
        test_add;
        test_relu;
        test_degenerate;
        test_wrap;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
